// File: rtl/lock_key_loader_if.sv
// lock_key_loader_if: serial key-load handshake and verified-key outputs.
interface lock_key_loader_if #(
    parameter int KEY_W    = 32,
    parameter int MAX_FAIL = 3
);
    localparam int FW = $clog2(MAX_FAIL + 1);
    logic             load_start;
    logic             key_sdi;
    logic             key_sdi_valid;
    logic             key_sdi_ready;
    logic [KEY_W-1:0] key_out;
    logic             key_loaded;
    logic             key_error;
    logic             lockout;
    logic [FW-1:0]    fail_cnt;
    modport master (
        output load_start, key_sdi, key_sdi_valid,
        input  key_sdi_ready, key_out, key_loaded, key_error, lockout, fail_cnt
    );
    modport slave (
        input  load_start, key_sdi, key_sdi_valid,
        output key_sdi_ready, key_out, key_loaded, key_error, lockout, fail_cnt
    );
endinterface

// File: rtl/lock_key_loader.sv
// lock_key_loader: serial key loader with XOR-slice checksum and failure lockout.
module lock_key_loader #(
    parameter int KEY_W    = 32,
    parameter int CHK_W    = 8,
    parameter int MAX_FAIL = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    lock_key_loader_if.slave  bus
);
    localparam int N  = KEY_W + CHK_W;
    localparam int NS = KEY_W / CHK_W;
    localparam int CW = $clog2(N + 1);
    localparam int FW = $clog2(MAX_FAIL + 1);

    typedef enum logic [2:0] {IDLE, SHIFT, CHECK, DONE, LOCK} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [N-1:0]     sh_q, sh_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             loaded_q, loaded_d;
    logic             err_q, err_d;
    logic             lock_q, lock_d;
    logic [FW-1:0]    fail_q, fail_d, fail_inc;
    logic [CHK_W-1:0] sum;
    logic             acc, last, match;

    always_comb begin
        sum = '0;
        for (int i = 0; i < NS; i++) sum ^= sh_q[i*CHK_W +: CHK_W];
    end

    // Frame arrives LSB first, so shifting in at the top leaves bit 0 at index 0.
    assign match    = sum == sh_q[N-1 -: CHK_W];
    assign acc      = state_q == SHIFT && bus.key_sdi_valid;
    assign last     = acc && cnt_q == CW'(N - 1);
    assign fail_inc = fail_q == FW'(MAX_FAIL) ? fail_q : fail_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        key_d    = key_q;
        loaded_d = loaded_q;
        err_d    = 1'b0;
        lock_d   = lock_q;
        fail_d   = fail_q;
        case (state_q)
            IDLE: if (bus.load_start) begin
                state_d = SHIFT;
                cnt_d   = '0;
                sh_d    = '0;
            end
            SHIFT: if (bus.load_start) begin
                cnt_d = '0;
                sh_d  = '0;
            end else if (acc) begin
                sh_d    = {bus.key_sdi, sh_q[N-1:1]};
                cnt_d   = cnt_q + 1'b1;
                state_d = last ? CHECK : SHIFT;
            end
            CHECK: if (match) begin
                key_d    = sh_q[KEY_W-1:0];
                loaded_d = 1'b1;
                state_d  = DONE;
            end else begin
                err_d   = 1'b1;
                fail_d  = fail_inc;
                lock_d  = fail_inc == FW'(MAX_FAIL);
                state_d = fail_inc == FW'(MAX_FAIL) ? LOCK : IDLE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sh_q     <= '0;
            key_q    <= '0;
            loaded_q <= 1'b0;
            err_q    <= 1'b0;
            lock_q   <= 1'b0;
            fail_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            key_q    <= key_d;
            loaded_q <= loaded_d;
            err_q    <= err_d;
            lock_q   <= lock_d;
            fail_q   <= fail_d;
        end
    end

    assign bus.key_sdi_ready = state_q == SHIFT;
    assign bus.key_out       = key_q;
    assign bus.key_loaded    = loaded_q;
    assign bus.key_error     = err_q;
    assign bus.lockout       = lock_q;
    assign bus.fail_cnt      = fail_q;
endmodule

// File: tb/tb_lock_key_loader.sv
// tb_lock_key_loader: scoreboard bench for lock_key_loader frame outcomes.
module tb_lock_key_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lock_key_loader_if bus();
    lock_key_loader dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    typedef struct packed {
        logic [31:0] key;
        logic        loaded;
        logic        err;
        logic        lock;
        logic [1:0]  fail;
    } exp_t;

    localparam logic [31:0] K = 32'hA5C30F96;

    exp_t q[$];
    exp_t e;
    int   checks = 0, failures = 0;
    int   n_acc = 0, n_err = 0;
    int   a0, e0;
    logic rdy_start, rdy_chk;
    logic [31:0] m_key;
    logic m_loaded, m_lock, m_done;
    int   m_fail;

    always @(posedge clk) begin
        if (bus.key_sdi_valid && bus.key_sdi_ready) n_acc++;
        if (bus.key_error) n_err++;
    end

    function automatic logic [7:0] cks(input logic [31:0] k);
        return k[7:0] ^ k[15:8] ^ k[23:16] ^ k[31:24];
    endfunction

    function automatic logic [36:0] got();
        return {bus.key_out, bus.key_loaded, bus.key_error, bus.lockout, bus.fail_cnt};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear;
        m_key = '0; m_loaded = 0; m_lock = 0; m_done = 0; m_fail = 0;
        q.delete();
    endtask

    task automatic do_reset;
        rst_n = 0;
        bus.load_start = 0; bus.key_sdi_valid = 0; bus.key_sdi = 0;
        step;
        rst_n = 1;
        step;
        model_clear;
    endtask

    task automatic send_frame(input logic [31:0] key, input logic [7:0] chk, input int nbits, input bit gaps);
        logic [39:0] fr;
        logic err;
        fr = {chk, key};
        bus.load_start = 1;
        step;
        bus.load_start = 0;
        rdy_start = bus.key_sdi_ready;
        for (int i = 0; i < nbits; i++) begin
            if (gaps && i > 0) begin
                bus.key_sdi_valid = 0;
                repeat ($urandom_range(1, 5)) step;
            end
            bus.key_sdi_valid = 1;
            bus.key_sdi = fr[i];
            step;
        end
        bus.key_sdi_valid = 0;
        rdy_chk = bus.key_sdi_ready;
        if (nbits == 40) begin
            err = 0;
            if (!m_lock && !m_done) begin
                if (chk == cks(key)) begin
                    m_done = 1; m_key = key; m_loaded = 1;
                end else begin
                    err = 1;
                    m_fail++;
                    if (m_fail == 3) m_lock = 1;
                end
            end
            q.push_back('{m_key, m_loaded, err, m_lock, 2'(m_fail)});
            step;
        end
    endtask

    task automatic test_reset;
        bus.load_start = 0; bus.key_sdi_valid = 0; bus.key_sdi = 0;
        model_clear;
        #1;
        checks++;
        if ({got(), bus.key_sdi_ready} !== 38'd0) begin
            failures++;
            $display("FAIL reset_values got=%h exp=0", {got(), bus.key_sdi_ready});
        end
        rst_n = 1;
        repeat (3) step;
        checks++;
        if ({got(), bus.key_sdi_ready} !== 38'd0) begin
            failures++;
            $display("FAIL idle_quiet got=%h exp=0", {got(), bus.key_sdi_ready});
        end
    endtask

    task automatic test_good;
        do_reset;
        a0 = n_acc; e0 = n_err;
        send_frame(K, 8'hFF, 40, 0);
        checks++;
        if (rdy_start !== 1'b1) begin failures++; $display("FAIL good_ready_after_start got=%b exp=1", rdy_start); end
        checks++;
        if (rdy_chk !== 1'b0) begin failures++; $display("FAIL good_ready_in_check got=%b exp=0", rdy_chk); end
        e = q.pop_front();
        checks++;
        if (got() !== e) begin failures++; $display("FAIL good_outcome got=%h exp=%h", got(), e); end
        checks++;
        if (n_acc - a0 !== 40 || n_err !== e0) begin
            failures++;
            $display("FAIL good_counts got acc=%0d err=%0d exp acc=40 err=0", n_acc - a0, n_err - e0);
        end
        a0 = n_acc;
        send_frame(32'h12345678, cks(32'h12345678), 40, 0);
        e = q.pop_front();
        checks++;
        if (got() !== e || rdy_start !== 1'b0 || n_acc !== a0) begin
            failures++;
            $display("FAIL done_ignores got=%h rdy=%b acc=%0d exp=%h rdy=0 acc=0", got(), rdy_start, n_acc - a0, e);
        end
    endtask

    task automatic test_bad;
        do_reset;
        e0 = n_err;
        send_frame(K, 8'h00, 40, 0);
        e = q.pop_front();
        checks++;
        if (got() !== e) begin failures++; $display("FAIL bad_outcome got=%h exp=%h", got(), e); end
        step;
        checks++;
        if (bus.key_error !== 1'b0 || n_err - e0 !== 1) begin
            failures++;
            $display("FAIL bad_pulse_width got err=%b pulses=%0d exp err=0 pulses=1", bus.key_error, n_err - e0);
        end
        send_frame(K, 8'hFF, 40, 0);
        e = q.pop_front();
        checks++;
        if (got() !== e) begin failures++; $display("FAIL bad_then_good got=%h exp=%h", got(), e); end
    endtask

    task automatic test_lockout;
        do_reset;
        for (int i = 0; i < 3; i++) begin
            send_frame(K, 8'h00, 40, 0);
            e = q.pop_front();
            checks++;
            if (got() !== e) begin failures++; $display("FAIL lockout_frame%0d got=%h exp=%h", i, got(), e); end
        end
        a0 = n_acc;
        send_frame(K, 8'hFF, 40, 0);
        e = q.pop_front();
        checks++;
        if (got() !== e || rdy_start !== 1'b0 || n_acc !== a0) begin
            failures++;
            $display("FAIL lockout_ignores got=%h rdy=%b acc=%0d exp=%h rdy=0 acc=0", got(), rdy_start, n_acc - a0, e);
        end
        repeat (4) step;
        checks++;
        if (bus.key_out !== 32'd0 || bus.lockout !== 1'b1) begin
            failures++;
            $display("FAIL lockout_hold got key=%h lock=%b exp key=0 lock=1", bus.key_out, bus.lockout);
        end
    endtask

    task automatic test_gaps;
        do_reset;
        a0 = n_acc;
        send_frame(K, 8'hFF, 40, 1);
        e = q.pop_front();
        checks++;
        if (got() !== e || n_acc - a0 !== 40) begin
            failures++;
            $display("FAIL gaps_outcome got=%h acc=%0d exp=%h acc=40", got(), n_acc - a0, e);
        end
    endtask

    task automatic test_abort;
        do_reset;
        a0 = n_acc; e0 = n_err;
        send_frame(32'hFFFF_0000, 8'h00, 10, 0);
        send_frame(K, 8'hFF, 40, 0);
        e = q.pop_front();
        checks++;
        if (got() !== e || n_acc - a0 !== 50 || n_err !== e0) begin
            failures++;
            $display("FAIL abort_restart got=%h acc=%0d err=%0d exp=%h acc=50 err=0", got(), n_acc - a0, n_err - e0, e);
        end
    endtask

    task automatic test_reset_mid;
        do_reset;
        send_frame(K, 8'hFF, 20, 0);
        rst_n = 0;
        #1;
        checks++;
        if ({got(), bus.key_sdi_ready} !== 38'd0) begin
            failures++;
            $display("FAIL reset_mid_frame got=%h exp=0", {got(), bus.key_sdi_ready});
        end
        step;
        rst_n = 1;
        step;
        model_clear;
        send_frame(K, 8'hFF, 40, 0);
        e = q.pop_front();
        checks++;
        if (got() !== e) begin failures++; $display("FAIL reset_mid_reload got=%h exp=%h", got(), e); end
        rst_n = 0;
        #1;
        checks++;
        if ({got(), bus.key_sdi_ready} !== 38'd0) begin
            failures++;
            $display("FAIL reset_in_done got=%h exp=0", {got(), bus.key_sdi_ready});
        end
        step;
        rst_n = 1;
        step;
        model_clear;
        send_frame(K, 8'hFF, 40, 1);
        e = q.pop_front();
        checks++;
        if (got() !== e) begin failures++; $display("FAIL reset_done_reload got=%h exp=%h", got(), e); end
    endtask

    initial begin
        test_reset;
        test_good;
        test_bad;
        test_lockout;
        test_gaps;
        test_abort;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lock_key_loader.md
# lock_key_loader

Sequential key-provisioning stage that sits directly upstream of the logic-locked c499 error-correction core and drives its 32 key inputs. The block receives the key as a serial frame with a checksum and verifies the checksum. It presents the key to the core only after a successful verification, holding the core's key lines at all-zero until then. Repeated failed frames cause a permanent lockout that only reset clears.

## Interface
- KEY_W, 32: key width; must be a multiple of CHK_W.
- CHK_W, 8: checksum width.
- MAX_FAIL, 3: number of failed frames that triggers lockout (≥1).
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- load_start  in  1  one-cycle request to begin (or restart) a frame.
- key_sdi  in  1  serial key/checksum data.
- key_sdi_valid  in  1  key_sdi carries a bit this cycle.
- key_sdi_ready  out  1  block accepts a bit this cycle.
- key_out  out  KEY_W  verified key; bit i drives core key input i (keyIn_0_i).
- key_loaded  out  1  key_out holds a verified key (level).
- key_error  out  1  one-cycle pulse on checksum mismatch.
- lockout  out  1  sticky; set when the failure count reaches MAX_FAIL.
- fail_cnt  out  $clog2(MAX_FAIL+1)  number of failed frames since reset.

## Operation
- Frame layout: KEY_W key bits, LSB first, followed by CHK_W checksum bits, LSB first.
- Checksum: XOR of the KEY_W/CHK_W consecutive CHK_W-bit slices of the key, with slice 0 = bits [CHK_W-1:0].
- Bit capture: a bit is accepted only when key_sdi_valid and key_sdi_ready are both 1; valid gaps of any length are legal.
- Incoming bits go to a shadow register. key_out is written only from a verified shadow and never shows a partial key.
- States and transitions:
  - IDLE: ready=0; load_start → SHIFT, clearing the bit counter and the shadow register.
  - SHIFT: ready=1; the counter increments on each accepted bit; acceptance of bit KEY_W+CHK_W-1 → CHECK.
  - CHECK (exactly 1 cycle, ready=0), on a match: key_out←shadow key, key_loaded←1, → DONE.
  - CHECK, on a mismatch: key_error pulses, fail_cnt increments; → LOCKOUT with lockout←1 if the new count equals MAX_FAIL, otherwise → IDLE.
  - DONE: terminal until reset; ready=0; load_start is ignored; key_out is held.
  - LOCKOUT: terminal until reset; ready=0; key_out stays 0; load_start is ignored.
- load_start during SHIFT: the frame is aborted and restarted (counter and shadow cleared). This does not count as a failure and raises no error.
- load_start during the CHECK cycle is ignored.
- fail_cnt saturates at MAX_FAIL.

## Timing
- Reset values: key_out=0, key_loaded=0, key_error=0, lockout=0, fail_cnt=0, key_sdi_ready=0, state=IDLE.
- Reset is asynchronous: all of the above take effect immediately on rst_n low, including mid-frame and from DONE or LOCKOUT.
- load_start sampled at edge E → key_sdi_ready=1 in the cycle after E.
- Final checksum bit accepted at edge F → CHECK during the cycle after F.
- key_out, key_loaded, key_error, fail_cnt and lockout update at edge F+1 and are visible from then on.
- key_error is high for exactly one cycle per failed frame.
- key_sdi_ready drops in the cycle after F, so no bit is accepted during CHECK.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Good frame: key 0xA5C30F96, checksum 0xFF, valid continuous → key_loaded=1 and key_out=0xA5C30F96 at F+1; fail_cnt=0; key_error never asserted.
- Bad checksum: key 0xA5C30F96 with checksum 0x00 → key_error pulse of 1 cycle at F+1; fail_cnt=1; key_out=0; state returns to IDLE; a following good frame then loads.
- Lockout: three frames with checksum 0x00 → lockout=1 and fail_cnt=3; a subsequent good frame gets key_sdi_ready=0 throughout and key_out stays 0 until reset.
- Valid gaps: the good frame with key_sdi_valid deasserted for 1–5 random cycles between bits → same result as the continuous case; exactly 40 bits accepted.
- Abort/restart: load_start after 10 bits, then a full good frame → key_out=0xA5C30F96; fail_cnt=0; no key_error.
- Reset mid-operation: rst_n low after bit 20, and again in DONE → all outputs 0 immediately; after release the state is IDLE and a new good frame loads.
